// File: rtl/flag_pkg.sv
// Shared flag and branch-condition types for the EX-stage flag/condition logic.
package flag_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_HS = 4'h2, CC_LO = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_code_e;

  typedef enum logic [1:0] {
    B     = 2'b00,
    BCOND = 2'b01,
    CBZ   = 2'b10,
    CBNZ  = 2'b11
  } cond_type_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARMv8 condition-code evaluator; pass=1 when the condition holds on flags_i.
module cond_eval
  import flag_pkg::*;
(
  input  flags_t     flags_i,
  input  cond_code_e cond_code_i,
  output logic       pass_o
);

  always_comb begin
    pass_o = 1'b0;
    case (cond_code_i)
      CC_EQ:   pass_o = flags_i.z;
      CC_NE:   pass_o = ~flags_i.z;
      CC_HS:   pass_o = flags_i.c;
      CC_LO:   pass_o = ~flags_i.c;
      CC_MI:   pass_o = flags_i.n;
      CC_PL:   pass_o = ~flags_i.n;
      CC_VS:   pass_o = flags_i.v;
      CC_VC:   pass_o = ~flags_i.v;
      CC_HI:   pass_o = flags_i.c & ~flags_i.z;
      CC_LS:   pass_o = ~flags_i.c | flags_i.z;
      CC_GE:   pass_o = (flags_i.n == flags_i.v);
      CC_LT:   pass_o = (flags_i.n != flags_i.v);
      CC_GT:   pass_o = ~flags_i.z & (flags_i.n == flags_i.v);
      CC_LE:   pass_o = flags_i.z | (flags_i.n != flags_i.v);
      CC_AL:   pass_o = 1'b1;
      CC_NV:   pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// EX-stage flag register with same-cycle forwarding, registered branch decision
// and a saturating taken-branch counter.
module flag_cond_unit
  import flag_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic             set_flags,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  input  logic             cond_valid,
  input  logic [1:0]       cond_type,
  input  logic [3:0]       cond_code,
  input  logic             reg_is_zero,
  input  logic             flush,
  output logic [3:0]       flags_q,
  output logic             decision_valid,
  output logic             take_branch,
  output logic [CNT_W-1:0] taken_count
);

  flags_t           flags_reg_q;
  flags_t           alu_flags;
  flags_t           eff_flags;
  logic             flag_wr;
  logic             req;
  logic             bcond_pass;
  logic             sel;
  logic             take_d;
  logic             valid_q;
  logic             take_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign flag_wr   = alu_valid & set_flags & ~flush;
  assign req       = cond_valid & ~flush;
  assign alu_flags = '{n: alu_negative, z: alu_zero, v: alu_overflow, c: alu_carry_out};
  // Forward the flags being written this cycle so a branch right behind a setter needs no stall.
  assign eff_flags = flag_wr ? alu_flags : flags_reg_q;

  cond_eval u_cond_eval (
    .flags_i     (eff_flags),
    .cond_code_i (cond_code_e'(cond_code)),
    .pass_o      (bcond_pass)
  );

  always_comb begin
    sel = 1'b0;
    case (cond_type_e'(cond_type))
      B:       sel = 1'b1;
      BCOND:   sel = bcond_pass;
      CBZ:     sel = reg_is_zero;
      CBNZ:    sel = ~reg_is_zero;
      default: sel = 1'b0;
    endcase
  end

  // Gate with the request so don't-care inputs never reach the registered outputs.
  assign take_d  = req ? sel : 1'b0;
  assign count_d = (take_d && (count_q != {CNT_W{1'b1}})) ? count_q + 1'b1 : count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg_q <= '0;
      valid_q     <= 1'b0;
      take_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      if (flag_wr) flags_reg_q <= alu_flags;
      valid_q <= req;
      take_q  <= take_d;
      count_q <= count_d;
    end
  end

  assign flags_q        = flags_reg_q;
  assign decision_valid = valid_q;
  assign take_branch    = take_q;
  assign taken_count    = count_q;

endmodule

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
- Consumer end of the ALU flag interface: captures the N/Z/V/C flags from the ALU of a flag-setting instruction (ADDS, SUBS, ANDS) into the architectural flag register.
- Evaluates branch conditions (B, B.cond, CBZ, CBNZ) against those flags.
- Forwards same-cycle ALU flags so a branch directly behind a flag setter needs no stall.
- Sits in EX beside the ALU; its registered branch decision drives PC select and flush logic.

Parameters:
CNT_W, 16, width of the saturating taken-branch counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU result in EX is valid this cycle
set_flags  input  1  instruction in EX writes flags
alu_negative  input  1  ALU negative flag
alu_zero  input  1  ALU zero flag
alu_overflow  input  1  ALU overflow flag
alu_carry_out  input  1  ALU carry-out flag
cond_valid  input  1  branch evaluation request this cycle
cond_type  input  2  00 B, 01 B.cond, 10 CBZ, 11 CBNZ
cond_code  input  4  ARMv8 condition field (B.cond only)
reg_is_zero  input  1  tested register equals zero (CBZ/CBNZ only)
flush  input  1  squash current-cycle request and flag write
flags_q  output  4  architectural flags {N,Z,V,C}
decision_valid  output  1  take_branch is meaningful this cycle
take_branch  output  1  registered branch-taken decision
taken_count  output  CNT_W  saturating count of taken branches

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, reset). On reset, every output is 0: flags_q=4'b0000, decision_valid=0, take_branch=0, taken_count=0. Reset overrides all other inputs in the same cycle. Reset mid-request discards the request, with no decision the next cycle.
- Flag write: flags_q <= {alu_negative, alu_zero, alu_overflow, alu_carry_out} on the edge where alu_valid & set_flags & ~flush. Otherwise flags_q holds.
- Effective flags for evaluation:
  - ALU flags when alu_valid & set_flags & ~flush in the same cycle (forwarding).
  - Otherwise flags_q.
- Condition table, evaluated on the effective flags:
  - EQ 0000: Z. NE 0001: ~Z.
  - HS 0010: C. LO 0011: ~C.
  - MI 0100: N. PL 0101: ~N.
  - VS 0110: V. VC 0111: ~V.
  - HI 1000: C&~Z. LS 1001: ~C|Z.
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: ~Z&(N==V). LE 1101: Z|(N!=V).
  - AL 1110 and 1111: 1.
- cond_type selection:
  - B: always taken.
  - B.cond: table result.
  - CBZ: reg_is_zero.
  - CBNZ: ~reg_is_zero.
  - CBZ/CBNZ ignore flags and cond_code.
- Latency: one cycle. When cond_valid & ~flush at edge k, decision_valid=1 and take_branch=result during cycle k+1.
  - With no request, decision_valid=0 and take_branch=0; take_branch is never high with decision_valid low.
  - Back-to-back requests give back-to-back decisions, with no bubble.
- flush: that cycle's request yields decision_valid=0 next cycle, and that cycle's flag write is suppressed. A decision already registered still presents for its one cycle; flush does not retract it.
- taken_count: increments by 1 on each edge where a registered decision goes taken (i.e., registers take_branch=1). It holds at 2^CNT_W-1 (saturates) and never wraps.
- Simultaneous flag write and B.cond request: the decision uses the new flags, and flags_q also updates.
- X-safety: cond_code, cond_type and reg_is_zero are don't-care when cond_valid=0. Outputs must not go X when those inputs are X.

Decomposition:
- Package flag_pkg:
  - typedef flags_t as a packed struct {n,z,v,c}.
  - enum cond_code_e with the 16 codes above.
  - enum cond_type_e {B, BCOND, CBZ, CBNZ}.
- Sub-module cond_eval: purely combinational. Inputs flags_t and cond_code_e; output 1-bit pass. Reused by any future conditional-select logic.
- flag_cond_unit contains the flag register, the forwarding mux, the decision pipeline register and the counter.

Test Plan:
1. Reset held 2 cycles with alu_valid=set_flags=1 and all flags=1 -> flags_q=0000, decision_valid=0, taken_count=0.
2. SUBS with N=0,Z=1,V=0,C=1 and same-cycle B.cond EQ -> next cycle decision_valid=1, take_branch=1, flags_q=0101. Then B.cond NE with no flag write -> take_branch=0.
3. Forwarding vs. stale flags: flags_q=0000, same-cycle flag write N=1,V=0 with B.cond LT -> take_branch=1, not the stale 0. Repeat with set_flags=0 -> take_branch=0.
4. Full sweep of all 16 cond_codes × 16 flag combinations against a reference model. 1110 and 1111 are always taken; GT with Z=0,N=1,V=1 -> taken.
5. flush with cond_valid=1 and a flag write -> decision_valid=0 next cycle and flags_q unchanged. CBZ with reg_is_zero=1 and CBNZ with reg_is_zero=1 -> take_branch=1, then 0.
6. CNT_W=4: 20 consecutive taken B requests -> taken_count=15 and holds at 15. Reset asserted mid-stream -> taken_count=0 and no decision next cycle.
